// File: rtl/bit_serializer.sv
// bit_serializer: loads a W-bit word and shifts it out LSB first on 'a',
// followed by GAP idle cycles and a one-cycle 'done' pulse on normal completion.
module bit_serializer #(
  parameter int unsigned W   = 8,
  parameter int unsigned GAP = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         abort,
  output logic         ready,
  output logic         a,
  output logic         a_valid,
  output logic         done
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;
  logic           fin_d;
  logic           ready_d, a_d, a_valid_d, done_d;

  // State, datapath and registered outputs; reset takes effect without a clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      ready   <= 1'b1;
      a       <= 1'b0;
      a_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      ready   <= ready_d;
      a       <= a_d;
      a_valid <= a_valid_d;
      done    <= done_d;
    end
  end

  // Next-state and datapath update; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    fin_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load && !abort) begin
          state_d = ST_SHIFT;
          sreg_d  = din;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          sreg_d = {1'b0, sreg_q[W-1:1]};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (GAP > 0) begin
              state_d = ST_GAP;
              gcnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
              fin_d   = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
          gcnt_d  = '0;
        end else if (gcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gcnt_d  = '0;
          fin_d   = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle, decoded from the next state
  always_comb begin
    ready_d   = 1'b0;
    a_valid_d = 1'b0;
    a_d       = 1'b0;
    done_d    = fin_d;
    if (state_d == ST_IDLE) begin
      ready_d = 1'b1;
    end
    if (state_d == ST_SHIFT) begin
      a_valid_d = 1'b1;
      a_d       = sreg_d[0];
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: stimulus queues expected bits and done
// pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_bit_serializer;

  localparam int unsigned W   = 8;
  localparam int unsigned GAP = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load;
  logic         abort;
  logic [W-1:0] din;
  logic         ready;
  logic         a;
  logic         a_valid;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  bit exp_bits[$];
  bit exp_done[$];
  bit exp_b;

  always #5 clk = ~clk;

  bit_serializer #(.W(W), .GAP(GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .din     (din),
    .abort   (abort),
    .ready   (ready),
    .a       (a),
    .a_valid (a_valid),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented bit and every done pulse is matched against the queues
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      if (exp_bits.size() == 0) begin
        check("unexpected_bit", 32'(a_valid), 32'd0);
      end else begin
        exp_b = exp_bits.pop_front();
        check("stream_bit", 32'(a), 32'(exp_b));
      end
    end else begin
      check("idle_a_zero", 32'(a), 32'd0);
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        void'(exp_done.pop_front());
        check("done_with_ready", 32'(ready), 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] d, input int nbits, input bit with_done);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(d[i]);
    if (with_done) exp_done.push_back(1'b1);
  endtask

  task automatic send(input logic [W-1:0] d);
    load = 1'b1;
    din  = d;
    step();
    load = 1'b0;
  endtask

  // Walk forward until done (bounded), counting valid and gap cycles on the way
  task automatic wait_done(output int vcnt, output int gcnt, output bit got);
    vcnt = 0;
    gcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (a_valid === 1'b1) vcnt++;
      else if (ready === 1'b0) gcnt++;
      step();
    end
  endtask

  task automatic frame_tail(input string tag);
    int v;
    int g;
    bit got;
    wait_done(v, g, got);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_valid_cycles"}, 32'(v), 32'(W));
    check({tag, "_gap_cycles"}, 32'(g), 32'(GAP));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int g;
    bit got;

    reset_n = 1'b1;
    load    = 1'b0;
    abort   = 1'b0;
    din     = '0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_a", 32'(a), 32'd0);
    check("reset_a_valid", 32'(a_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Basic frame: 1,1,0,1,0,1,1,0 then 3 gap cycles then done
    push_frame(8'b0110_1011, W, 1'b1);
    send(8'b0110_1011);
    frame_tail("frame_6b");
    step();

    // Frame containing a run of ones in bits 3..7
    push_frame(8'b1111_1011, W, 1'b1);
    send(8'b1111_1011);
    frame_tail("frame_fb");
    step();

    // Load while busy is ignored; din change after acceptance has no effect
    push_frame(8'hA5, W, 1'b1);
    send(8'hA5);
    step();
    step();
    load = 1'b1;
    din  = 8'hFF;
    step();
    check("busy_load_ready_low", 32'(ready), 32'd0);
    load = 1'b0;
    din  = 8'h00;
    wait_done(v, g, got);
    check("a5_done_seen", 32'(got), 32'd1);
    repeat (15) step();

    // Abort during bit 4: five bits out, then idle with no done
    push_frame(8'hFF, 5, 1'b0);
    send(8'hFF);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_a_valid", 32'(a_valid), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_a", 32'(a), 32'd0);
    repeat (12) step();
    push_frame(8'h01, W, 1'b1);
    send(8'h01);
    frame_tail("after_abort");
    step();

    // Asynchronous reset mid-clock during bit 3
    push_frame(8'h0F, 3, 1'b0);
    send(8'h0F);
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_a", 32'(a), 32'd0);
    check("async_rst_a_valid", 32'(a_valid), 32'd0);
    check("async_rst_ready", 32'(ready), 32'd1);
    check("async_rst_done", 32'(done), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    push_frame(8'h5A, W, 1'b1);
    send(8'h5A);
    frame_tail("post_reset");
    step();

    // Abort wins over a coincident load in IDLE
    abort = 1'b1;
    load  = 1'b1;
    din   = 8'hFF;
    step();
    check("abort_load_ready", 32'(ready), 32'd1);
    check("abort_load_a_valid", 32'(a_valid), 32'd0);
    abort = 1'b0;
    load  = 1'b0;
    step();

    // Load held across done: second frame starts right after the done cycle
    push_frame(8'h3C, W, 1'b1);
    push_frame(8'h3C, W, 1'b1);
    load = 1'b1;
    din  = 8'h3C;
    step();
    frame_tail("b2b_first");
    step();
    load = 1'b0;
    check("b2b_second_starts", 32'(a_valid), 32'd1);
    frame_tail("b2b_second");

    repeat (6) step();
    check("bits_left", 32'(exp_bits.size()), 32'd0);
    check("dones_left", 32'(exp_done.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
